// File: rtl/idu_pkg.sv
// Shared decode definitions: opcodes, instruction formats, operand-mux codes and
// the decoded-instruction bundle carried by the decode slot.
package idu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {IT_R, IT_I, IT_S, IT_B, IT_U, IT_J} itype_e;

  typedef enum logic [1:0] {AM1_ZERO = 2'd0, AM1_RS1 = 2'd1, AM1_PC = 2'd2} amux1_e;
  typedef enum logic [1:0] {AM2_ZERO = 2'd0, AM2_RS2 = 2'd1, AM2_IMM = 2'd2} amux2_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  func3;
    logic [2:0]  func_eu;
    logic        alt;
    logic [1:0]  amux1;
    logic [1:0]  amux2;
    logic        wen;
    logic        mem_ren;
    logic        mem_wen;
    logic        branch;
    logic        jump;
    logic        illegal;
  } dec_t;

  function automatic logic [31:0] imm_of(input itype_e t, input logic [31:0] i);
    case (t)
      IT_I:    imm_of = {{20{i[31]}}, i[31:20]};
      IT_S:    imm_of = {{20{i[31]}}, i[31:25], i[11:7]};
      IT_B:    imm_of = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IT_U:    imm_of = {i[31:12], 12'b0};
      IT_J:    imm_of = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm_of = '0;
    endcase
  endfunction

endpackage

// File: rtl/idu_decode.sv
// Combinational RV32 decoder: instruction word -> control bundle.
// IDU_RVE_EN restricts register fields to x0..x15 (others decode as illegal).
module idu_decode
  import idu_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  itype_e     ity;
  logic       known;
  logic       bad_fn;
  logic       rve_bad;
  logic       ill;
  dec_t       raw;

  always_comb begin
    opc    = inst[6:0];
    f3     = inst[14:12];
    f7     = inst[31:25];
    ity    = IT_R;
    known  = 1'b1;
    bad_fn = 1'b0;
    raw    = '0;
    case (opc)
      OPC_LUI: begin
        ity = IT_U; raw.wen = 1'b1; raw.amux1 = AM1_ZERO; raw.amux2 = AM2_IMM;
      end
      OPC_AUIPC: begin
        ity = IT_U; raw.wen = 1'b1; raw.amux1 = AM1_PC; raw.amux2 = AM2_IMM;
      end
      OPC_JAL: begin
        ity = IT_J; raw.wen = 1'b1; raw.jump = 1'b1; raw.amux1 = AM1_PC; raw.amux2 = AM2_IMM;
      end
      OPC_JALR: begin
        ity = IT_I; raw.wen = 1'b1; raw.jump = 1'b1; raw.amux1 = AM1_RS1; raw.amux2 = AM2_IMM;
        bad_fn = (f3 != 3'd0);
      end
      OPC_BRANCH: begin
        ity = IT_B; raw.branch = 1'b1; raw.amux1 = AM1_RS1; raw.amux2 = AM2_RS2;
        bad_fn = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        ity = IT_I; raw.wen = 1'b1; raw.mem_ren = 1'b1; raw.amux1 = AM1_RS1; raw.amux2 = AM2_IMM;
        bad_fn = (f3 == 3'd3) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        ity = IT_S; raw.mem_wen = 1'b1; raw.amux1 = AM1_RS1; raw.amux2 = AM2_IMM;
        bad_fn = (f3 > 3'd2);
      end
      OPC_OPIMM: begin
        ity = IT_I; raw.wen = 1'b1; raw.amux1 = AM1_RS1; raw.amux2 = AM2_IMM;
        raw.func_eu = f3;
        // Only the shift forms carry a funct7; elsewhere inst[30] is immediate data.
        if (f3 == 3'd1) bad_fn = (f7 != 7'h00);
        if (f3 == 3'd5) begin
          bad_fn  = (f7 != 7'h00) && (f7 != 7'h20);
          raw.alt = inst[30];
        end
      end
      OPC_OP: begin
        ity = IT_R; raw.wen = 1'b1; raw.amux1 = AM1_RS1; raw.amux2 = AM2_RS2;
        raw.func_eu = f3;
        raw.alt     = inst[30];
        bad_fn = !((f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5)));
      end
      OPC_SYSTEM: begin
        ity = IT_I; raw.amux2 = AM2_IMM;
        bad_fn = (f3 == 3'd4);
      end
      default: known = 1'b0;
    endcase

    raw.func3 = (ity == IT_U || ity == IT_J) ? 3'd0 : f3;
    raw.rs1   = (ity == IT_R || ity == IT_I || ity == IT_S || ity == IT_B) ? inst[19:15] : 5'd0;
    raw.rs2   = (ity == IT_R || ity == IT_S || ity == IT_B) ? inst[24:20] : 5'd0;
    raw.rd    = (ity == IT_R || ity == IT_I || ity == IT_U || ity == IT_J) ? inst[11:7] : 5'd0;
    raw.imm   = (ity == IT_R) ? 32'd0 : imm_of(ity, inst);

`ifdef IDU_RVE_EN
    rve_bad = raw.rs1[4] | raw.rs2[4] | raw.rd[4];
`else
    rve_bad = 1'b0;
`endif

    ill = !known || (inst[1:0] != 2'b11) || bad_fn || rve_bad;
    dec = raw;
    if (ill) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/idu_pipe.sv
// Instruction-decode stage: fetch FIFO feeding one registered decode slot.
// Build with IDU_RVE_EN to decode for the 16-register RV32E register file.
module idu_pipe
  import idu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [4:0]               rd,
  output logic [31:0]              imm,
  output logic [2:0]               func3,
  output logic [2:0]               funcEU,
  output logic                     alt,
  output logic [1:0]               amux1,
  output logic [1:0]               amux2,
  output logic                     wen,
  output logic                     mem_ren,
  output logic                     mem_wen,
  output logic                     branch,
  output logic                     jump,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } ent_t;

  ent_t            mem_q [DEPTH];
  ent_t            mem_d [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     occ_q, occ_d;
  logic            slot_vld_q, slot_vld_d;
  dec_t            slot_q, slot_d;
  logic [PC_W-1:0] slot_pc_q, slot_pc_d;

  ent_t            head;
  dec_t            head_dec;
  logic            push, pop;

  assign head = mem_q[rptr_q];

  idu_decode u_dec (
    .inst (head.inst),
    .dec  (head_dec)
  );

  always_comb begin
    // The slot refills whenever it is empty or being consumed this cycle.
    pop      = (occ_q != '0) && (!slot_vld_q || out_ready);
    // A full FIFO still takes a new entry when its head leaves in the same cycle.
    in_ready = ((occ_q != FULL) || pop) && !flush && !rst;
    push     = in_valid && in_ready;

    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    occ_d      = occ_q;
    slot_d     = slot_q;
    slot_pc_d  = slot_pc_q;
    slot_vld_d = slot_vld_q;

    if (push) begin
      mem_d[wptr_q] = '{inst: in_inst, pc: in_pc};
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) begin
      slot_d     = head_dec;
      slot_pc_d  = head.pc;
      slot_vld_d = 1'b1;
      rptr_d     = rptr_q + AW'(1);
    end else if (out_ready) begin
      slot_vld_d = 1'b0;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase

    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      occ_d      = '0;
      slot_vld_d = 1'b0;
      slot_d     = '0;
      slot_pc_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      slot_vld_q <= 1'b0;
      slot_q     <= '0;
      slot_pc_q  <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
      slot_vld_q <= slot_vld_d;
      slot_q     <= slot_d;
      slot_pc_q  <= slot_pc_d;
    end
  end

  // Storage is qualified by occupancy, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid = slot_vld_q;
  assign out_pc    = slot_pc_q;
  assign rs1       = slot_q.rs1;
  assign rs2       = slot_q.rs2;
  assign rd        = slot_q.rd;
  assign imm       = slot_q.imm;
  assign func3     = slot_q.func3;
  assign funcEU    = slot_q.func_eu;
  assign alt       = slot_q.alt;
  assign amux1     = slot_q.amux1;
  assign amux2     = slot_q.amux2;
  assign wen       = slot_q.wen;
  assign mem_ren   = slot_q.mem_ren;
  assign mem_wen   = slot_q.mem_wen;
  assign branch    = slot_q.branch;
  assign jump      = slot_q.jump;
  assign illegal   = slot_q.illegal;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: queue/slot reference model with a table-driven RV32 decode,
// compared every cycle, plus directed literal checks.
module tb_idu_pipe;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
`ifdef IDU_RVE_EN
  localparam bit RVE = 1'b1;
`else
  localparam bit RVE = 1'b0;
`endif

  logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, imm;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] func3, funcEU;
  logic alt, wen, mem_ren, mem_wen, branch, jump, illegal;
  logic [1:0] amux1, amux2;
  logic [$clog2(DEPTH):0] occupancy;

  idu_pipe #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .func3(func3), .funcEU(funcEU),
    .alt(alt), .amux1(amux1), .amux2(amux2), .wen(wen), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .branch(branch), .jump(jump), .illegal(illegal),
    .occupancy(occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic [31:0] imm;
    logic [2:0] f3, feu;
    logic alt;
    logic [1:0] a1, a2;
    logic wen, mr, mw, br, jp, ill;
  } exp_t;

  // Reference decode straight from the ISA tables.
  function automatic exp_t ref_dec(input logic [31:0] x);
    exp_t e;
    int op, f3, f7;
    bit r, i, s, b, u, j, ok;
    logic signed [31:0] sx;
    logic [31:0] s20, s25, s31;
    e = '0; r = 0; i = 0; s = 0; b = 0; u = 0; j = 0; ok = 1;
    op = int'(x[6:0]); f3 = int'(x[14:12]); f7 = int'(x[31:25]);
    sx = $signed(x); s20 = sx >>> 20; s25 = sx >>> 25; s31 = sx >>> 31;
    case (op)
      'h37: begin u = 1; e.wen = 1; e.a1 = 0; e.a2 = 2; end
      'h17: begin u = 1; e.wen = 1; e.a1 = 2; e.a2 = 2; end
      'h6f: begin j = 1; e.wen = 1; e.jp = 1; e.a1 = 2; e.a2 = 2; end
      'h67: begin i = 1; e.wen = 1; e.jp = 1; e.a1 = 1; e.a2 = 2; ok = (f3 == 0); end
      'h63: begin b = 1; e.br = 1; e.a1 = 1; e.a2 = 1; ok = (f3 != 2 && f3 != 3); end
      'h03: begin i = 1; e.wen = 1; e.mr = 1; e.a1 = 1; e.a2 = 2; ok = (f3 inside {0, 1, 2, 4, 5}); end
      'h23: begin s = 1; e.mw = 1; e.a1 = 1; e.a2 = 2; ok = (f3 <= 2); end
      'h13: begin
        i = 1; e.wen = 1; e.a1 = 1; e.a2 = 2; e.feu = x[14:12];
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) begin ok = (f7 == 0 || f7 == 32); e.alt = (f7 == 32); end
      end
      'h33: begin
        r = 1; e.wen = 1; e.a1 = 1; e.a2 = 1; e.feu = x[14:12]; e.alt = (f7 == 32);
        ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
      end
      'h73: begin i = 1; e.a2 = 2; ok = (f3 != 4); end
      default: ok = 0;
    endcase
    if (r | i | s | b) e.rs1 = x[19:15];
    if (r | s | b) e.rs2 = x[24:20];
    if (r | i | u | j) e.rd = x[11:7];
    if (r | i | s | b) e.f3 = x[14:12];
    if (i) e.imm = s20;
    if (s) e.imm = (s25 << 5) | ((x >> 7) & 32'h1f);
    if (b) e.imm = (s31 << 12) | (((x >> 7) & 32'h1) << 11) | (((x >> 25) & 32'h3f) << 5) | (((x >> 8) & 32'hf) << 1);
    if (u) e.imm = x & 32'hfffff000;
    if (j) e.imm = (s31 << 20) | (x & 32'h000ff000) | (((x >> 20) & 32'h1) << 11) | (((x >> 21) & 32'h3ff) << 1);
    if (RVE && (e.rs1[4] || e.rs2[4] || e.rd[4])) ok = 0;
    if (!ok) begin e = '0; e.ill = 1; end
    return e;
  endfunction

  logic [63:0] dut_bundle;
  assign dut_bundle = {rs1, rs2, rd, imm, func3, funcEU, alt, amux1, amux2,
                       wen, mem_ren, mem_wen, branch, jump, illegal};

  // Model: queue of {inst,pc} plus one held slot.
  logic [63:0] m_q[$];
  bit          m_sv = 1'b0;
  bit          m_zero = 1'b1;
  logic [31:0] m_inst = '0;
  logic [31:0] m_pc = '0;

  initial begin
    bit pop, push, exp_rdy;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_rdy = !rst && !flush &&
                  ((m_q.size() < DEPTH) || (m_q.size() > 0 && (!m_sv || out_ready)));
        chk("occupancy", occupancy, m_q.size());
        chk("out_valid", out_valid, m_sv);
        chk("in_ready", in_ready, exp_rdy);
        if (m_sv) begin
          chk("decode", dut_bundle, ref_dec(m_inst));
          chk("out_pc", out_pc, m_pc);
        end else if (m_zero) begin
          chk("reset_fields", dut_bundle, 64'd0);
          chk("reset_pc", out_pc, 32'd0);
        end
      end
      // Advance to the state the coming rising edge produces.
      if (rst) begin
        m_q.delete(); m_sv = 0; m_pc = '0; m_zero = 1;
      end else if (flush) begin
        m_q.delete(); m_sv = 0;
      end else begin
        pop  = (m_q.size() > 0) && (!m_sv || out_ready);
        push = in_valid && ((m_q.size() < DEPTH) || pop);
        if (pop) begin
          {m_inst, m_pc} = m_q.pop_front(); m_sv = 1; m_zero = 0;
        end else if (out_ready) begin
          m_sv = 0;
        end
        if (push) m_q.push_back({in_inst, in_pc});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Push one instruction into an empty pipe and hold it in the slot.
  task automatic send_one(input logic [31:0] ins, input logic [31:0] pc, output int lat);
    out_ready = 0; in_valid = 1; in_inst = ins; in_pc = pc;
    tick();
    in_valid = 0; lat = 0;
    @(negedge clk);
    chk("no_zero_latency", out_valid, 1'b0);
    while (lat < 6) begin
      tick(); lat++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic drain();
    tick(); out_ready = 1; tick();
  endtask

  logic [31:0] prog [14] = '{
    32'h123452B7, 32'h00001197, 32'h008000EF, 32'h00008067, 32'hFE208EE3,
    32'h00412303, 32'h00309093, 32'h40415113, 32'h402081B3, 32'h00000073,
    32'h0020A063, 32'h01DF6FB3, 32'hFFFFFFFF, 32'h40309093};
  logic [15:0] stall = 16'b1011_0010_1110_0101;

  initial begin
    int lat, k, cyc;
    logic [31:0] w;
    rst = 1; flush = 0; in_valid = 0; in_inst = '0; in_pc = '0; out_ready = 1;
    tick();
    chk_en = 1;
    tick();
    @(negedge clk);
    chk("rst_in_ready_low", in_ready, 1'b0);
    chk("rst_occ", occupancy, 0);
    tick(); rst = 0;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1'b1);
    tick();

    // addi x1,x2,-1
    send_one(32'hFFF10093, 32'h100, lat);
    chk("addi_latency", lat, 1);
    chk("addi_rs1", rs1, 2); chk("addi_rd", rd, 1);
    chk("addi_imm", imm, 32'hFFFFFFFF);
    chk("addi_amux1", amux1, 1); chk("addi_amux2", amux2, 2); chk("addi_wen", wen, 1);
    drain();

    // sw x5,8(x2)
    send_one(32'h00512423, 32'h104, lat);
    chk("sw_mem_wen", mem_wen, 1); chk("sw_wen", wen, 0);
    chk("sw_imm", imm, 8); chk("sw_amux2", amux2, 2); chk("sw_rs2", rs2, 5);
    drain();

    send_one(32'h00000000, 32'h108, lat);
    chk("zero_illegal", illegal, 1); chk("zero_wen", wen, 0);
    drain();
    send_one(32'h022080B3, 32'h10C, lat);
    chk("f7_01_illegal", illegal, 1); chk("f7_01_wen", wen, 0);
    drain();
    send_one(32'h00208833, 32'h110, lat);
    chk("x16_illegal", illegal, RVE); chk("x16_wen", wen, !RVE);
    chk("x16_rd", rd, RVE ? 5'd0 : 5'd16);
    drain();

    // Five pushes with out_ready low: one in slot, four queued.
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      w = 32'h00000093 | (32'(i) << 20);
      in_valid = 1; in_inst = w; in_pc = 32'h300 + 32'(4 * i);
      tick();
    end
    in_inst = 32'h00500093; in_pc = 32'h314;
    @(negedge clk);
    chk("full_occ", occupancy, 4); chk("full_in_ready", in_ready, 0);
    chk("full_out_pc", out_pc, 32'h300);
    tick(); out_ready = 1;
    @(negedge clk);
    chk("full_poppush_ready", in_ready, 1);
    tick(); in_valid = 0;
    @(negedge clk);
    chk("full_poppush_occ", occupancy, 4); chk("drain_pc1", out_pc, 32'h304);
    for (int j = 2; j <= 5; j++) begin
      tick();
      @(negedge clk);
      chk("drain_vld", out_valid, 1); chk("drain_pc", out_pc, 32'h300 + 32'(4 * j));
    end
    tick();
    @(negedge clk);
    chk("drained_vld", out_valid, 0); chk("drained_occ", occupancy, 0);

    // Flush with three queued and a simultaneous push.
    tick(); out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_inst = 32'h00100093; in_pc = 32'h400 + 32'(4 * i);
      tick();
    end
    in_valid = 0;
    @(negedge clk);
    chk("pre_flush_occ", occupancy, 3);
    tick(); flush = 1; in_valid = 1; in_pc = 32'h4FC;
    tick(); flush = 0; in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("flush_occ", occupancy, 0); chk("flush_vld", out_valid, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("flush_push_lost", out_valid, 0);

    // Reset while full.
    tick(); out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_inst = 32'h00200113; in_pc = 32'h500 + 32'(4 * i);
      tick();
    end
    in_valid = 0;
    @(negedge clk);
    chk("pre_rst_occ", occupancy, 4);
    tick(); rst = 1;
    tick();
    @(negedge clk);
    chk("rst_full_occ", occupancy, 0); chk("rst_full_vld", out_valid, 0);
    tick(); rst = 0; out_ready = 1;
    @(negedge clk);
    chk("rst_release_ready", in_ready, 1);
    tick();

    // Back-to-back stream, then the same stream against a stall pattern.
    for (int pass = 0; pass < 2; pass++) begin
      k = 0; cyc = 0;
      while (k < 14 && cyc < 200) begin
        in_valid = 1; in_inst = prog[k]; in_pc = 32'h2000 + 32'(4 * k) + 32'(pass * 'h100);
        out_ready = (pass == 0) ? 1'b1 : stall[cyc % 16];
        @(negedge clk);
        lat = int'(in_ready);
        tick();
        if (lat != 0) k++;
        cyc++;
      end
      chk("stream_done", k, 14);
      if (pass == 0) chk("stream_rate", cyc, 14);
      in_valid = 0; out_ready = 1;
      repeat (DEPTH + 3) tick();
      @(negedge clk);
      chk("stream_empty_occ", occupancy, 0); chk("stream_empty_vld", out_valid, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
